exe_wb_arbiter: RTL and testbench
=================================

Name: exe_wb_arbiter

Overview:
- Writeback arbiter directly downstream of the execution units: ALU, integer divider, FPU, FP divider, CSR access and memory access.
- Collects their active-low writeback requests and grants one unit per cycle, round-robin.
- Registers the winner onto the common-data-bus broadcast consumed by the reorder buffer and the issue-queue wakeup logic.
- Also supports back-pressure from the ROB and a pipeline flush.

Parameters:
- DATA, 32, writeback data width.
- UNITS, 6, number of requesting units. Index order: 0 ALU, 1 DIV, 2 FPU, 3 FDIV, 4 CSR, 5 MEM.
- RF_ADDR, 6, destination register index width (integer and FP files combined).
- ROB_ID, 5, reorder-buffer tag width.

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- wb_req_  in  UNITS  per-unit writeback request, active low
- wb_rd  in  UNITS*RF_ADDR  per-unit destination register, slot i at bits [i*RF_ADDR +: RF_ADDR]
- wb_rob_id  in  UNITS*ROB_ID  per-unit ROB tag
- wb_data  in  UNITS*DATA  per-unit result
- wb_exp_  in  UNITS  per-unit exception flag, active low
- wb_ack_  out  UNITS  per-unit grant, active low, combinational
- cdb_stall_  in  1  ROB cannot accept a broadcast this cycle, active low
- flush_  in  1  pipeline flush, active low
- cdb_valid_  out  1  broadcast valid, active low, registered
- cdb_rd  out  RF_ADDR  broadcast destination
- cdb_rob_id  out  ROB_ID  broadcast tag
- cdb_data  out  DATA  broadcast data
- cdb_exp_  out  1  broadcast exception flag
- conflict_cnt  out  16  count of cycles with two or more requests pending

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_, asynchronous and active-low.
- Reset values:
  - cdb_valid_ = 1 (idle); cdb_rd, cdb_rob_id and cdb_data = 0; cdb_exp_ = 1.
  - Round-robin pointer = 0; conflict_cnt = 0.
  - wb_ack_ = all ones while reset_ is low.
- Request contract:
  - A unit drives wb_req_[i]=0 and holds wb_rd, wb_rob_id, wb_data and wb_exp_ stable until it samples wb_ack_[i]=0 at a rising edge.
  - It releases or reissues the request on the following cycle.
- Grant:
  - wb_ack_ is combinational from wb_req_, the pointer, cdb_stall_ and flush_.
  - At most one bit of wb_ack_ is low.
  - The winner is the first requesting index searched from pointer upward, wrapping at UNITS-1 back to 0.
  - No grant when cdb_stall_=0 or flush_=0.
- Latency: a grant at edge N drives cdb_valid_=0 with the winner's fields for exactly the cycle after edge N, i.e. one cycle.
- Output register: cdb_valid_ is 1 in any cycle with no grant. Data fields hold their last value when idle.
- Pointer: on a grant to index g, the pointer becomes g+1, or 0 when g=UNITS-1. The pointer is unchanged when there is no grant.
- Fairness: a continuously requesting unit is granted within UNITS cycles when the ROB is not stalling.
- Stall:
  - cdb_stall_=0 blocks new grants.
  - A broadcast already registered still appears; the ROB absorbs one in-flight entry.
- Flush:
  - flush_=0 forces cdb_valid_=1 at the next edge, dropping any registered broadcast, and blocks grants in that cycle.
  - Pending requests stay pending. Units clear their own requests on flush.
- Simultaneous flush and stall: flush wins; the output clears.
- conflict_cnt:
  - Increments when two or more wb_req_ bits are 0 and cdb_stall_=1 and flush_=1.
  - Saturates at 16'hFFFF with no wrap.
- Reset mid-operation: all state returns to reset values asynchronously. Requests present when reset_ deasserts are arbitrated from pointer 0.
- Requests never granted produce no output. Dropping a request without an ack is illegal and is flagged by an assertion in simulation.

Test Plan:
- Single request: after reset, unit 0 requests with rd=5, rob_id=3, data=32'hDEADBEEF.
  - Required: wb_ack_[0]=0 the same cycle.
  - Required: next cycle cdb_valid_=0, cdb_rd=5, cdb_rob_id=3, cdb_data=32'hDEADBEEF, cdb_exp_=1. Pointer becomes 1.
- Round-robin: units 0, 2 and 5 request continuously from pointer 0.
  - Required: grant order 0, 2, 5, 0, 2, 5.
  - Required: conflict_cnt increases by 1 per cycle while two or more remain.
- Stall: unit 1 requests while cdb_stall_=0 for 3 cycles.
  - Required: no ack and cdb_valid_=1 during the stall.
  - Required: ack on the first cycle after cdb_stall_=1; broadcast one cycle later.
- Flush: grant unit 4 at edge N and assert flush_=0 in cycle N+1.
  - Required: the broadcast is visible in cycle N+1 and cdb_valid_=1 from edge N+2.
  - Required: unit 3 requesting in cycle N+1 gets no ack that cycle.
- Wrap and saturation:
  - Pointer at 5 with units 5 and 0 requesting: required order 5 then 0.
  - Preload conflict_cnt to 16'hFFFE with sustained conflicts: required value holds at 16'hFFFF.
- Async reset mid-burst: assert reset_ low between edges while cdb_valid_=0.
  - Required: cdb_valid_=1, wb_ack_ all ones and conflict_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exe_wb_arbiter_if.sv
// Writeback request bus between the execution units and the CDB arbiter,
// plus the registered common-data-bus broadcast and conflict statistic.
interface exe_wb_arbiter_if #(
    parameter int unsigned DATA    = 32,
    parameter int unsigned UNITS   = 6,
    parameter int unsigned RF_ADDR = 6,
    parameter int unsigned ROB_ID  = 5
);
    logic [UNITS-1:0]         wb_req_;
    logic [UNITS*RF_ADDR-1:0] wb_rd;
    logic [UNITS*ROB_ID-1:0]  wb_rob_id;
    logic [UNITS*DATA-1:0]    wb_data;
    logic [UNITS-1:0]         wb_exp_;
    logic [UNITS-1:0]         wb_ack_;
    logic                     cdb_stall_;
    logic                     flush_;
    logic                     cdb_valid_;
    logic [RF_ADDR-1:0]       cdb_rd;
    logic [ROB_ID-1:0]        cdb_rob_id;
    logic [DATA-1:0]          cdb_data;
    logic                     cdb_exp_;
    logic [15:0]              conflict_cnt;

    modport master (
        output wb_req_, wb_rd, wb_rob_id, wb_data, wb_exp_, cdb_stall_, flush_,
        input  wb_ack_, cdb_valid_, cdb_rd, cdb_rob_id, cdb_data, cdb_exp_, conflict_cnt
    );

    modport slave (
        input  wb_req_, wb_rd, wb_rob_id, wb_data, wb_exp_, cdb_stall_, flush_,
        output wb_ack_, cdb_valid_, cdb_rd, cdb_rob_id, cdb_data, cdb_exp_, conflict_cnt
    );
endinterface

// File: rtl/exe_wb_arbiter.sv
// Round-robin writeback arbiter: grants one execution unit per cycle and
// registers the winner onto the common data bus for the ROB and wakeup logic.
module exe_wb_arbiter #(
    parameter int unsigned DATA    = 32,
    parameter int unsigned UNITS   = 6,
    parameter int unsigned RF_ADDR = 6,
    parameter int unsigned ROB_ID  = 5
) (
    input  logic            clk,
    input  logic            reset_,
    exe_wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(UNITS - 1);
    localparam logic [PTR_W:0]   WRAP = (PTR_W + 1)'(UNITS);

    logic [UNITS-1:0]   req_act;
    logic               multi_req;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     cand_sum;
    logic [PTR_W-1:0]   cand;
    logic [UNITS-1:0]   ack_n;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [RF_ADDR-1:0] cdb_rd_q, cdb_rd_d;
    logic [ROB_ID-1:0]  cdb_rob_id_q, cdb_rob_id_d;
    logic [DATA-1:0]    cdb_data_q, cdb_data_d;
    logic               cdb_exp_q, cdb_exp_d;
    logic [15:0]        cnt_q, cnt_d;

    assign req_act = ~bus.wb_req_;
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi_req = |(req_act & (req_act - UNITS'(1)));

    always_comb begin : arbitrate
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        if (reset_ && bus.cdb_stall_ && bus.flush_) begin
            for (int unsigned k = 0; k < UNITS; k++) begin
                cand_sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
                if (cand_sum >= WRAP) begin
                    cand_sum = cand_sum - WRAP;
                end
                cand = cand_sum[PTR_W-1:0];
                if (!grant_vld && req_act[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin : ack_decode
        ack_n = '1;
        if (grant_vld) begin
            ack_n[grant_idx] = 1'b0;
        end
    end

    assign bus.wb_ack_ = ack_n;

    always_comb begin : next_state
        ptr_d        = ptr_q;
        cdb_valid_d  = ~grant_vld;
        cdb_rd_d     = cdb_rd_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_data_d   = cdb_data_q;
        cdb_exp_d    = cdb_exp_q;
        cnt_d        = cnt_q;
        if (grant_vld) begin
            ptr_d        = (grant_idx == LAST) ? '0 : grant_idx + PTR_W'(1);
            cdb_rd_d     = bus.wb_rd[32'(grant_idx) * RF_ADDR +: RF_ADDR];
            cdb_rob_id_d = bus.wb_rob_id[32'(grant_idx) * ROB_ID +: ROB_ID];
            cdb_data_d   = bus.wb_data[32'(grant_idx) * DATA +: DATA];
            cdb_exp_d    = bus.wb_exp_[grant_idx];
        end
        if (multi_req && bus.cdb_stall_ && bus.flush_ && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ptr_q        <= '0;
            cdb_valid_q  <= 1'b1;
            cdb_rd_q     <= '0;
            cdb_rob_id_q <= '0;
            cdb_data_q   <= '0;
            cdb_exp_q    <= 1'b1;
            cnt_q        <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rd_q     <= cdb_rd_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_data_q   <= cdb_data_d;
            cdb_exp_q    <= cdb_exp_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.cdb_valid_   = cdb_valid_q;
    assign bus.cdb_rd       = cdb_rd_q;
    assign bus.cdb_rob_id   = cdb_rob_id_q;
    assign bus.cdb_data     = cdb_data_q;
    assign bus.cdb_exp_     = cdb_exp_q;
    assign bus.conflict_cnt = cnt_q;

    // A pending request may only go away after an ack, or around a flush.
    for (genvar u = 0; u < UNITS; u++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk) disable iff (!reset_)
            (!bus.wb_req_[u] && bus.wb_ack_[u] && bus.flush_) |=> (!bus.wb_req_[u] || !bus.flush_));
    end
endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Scoreboard bench for exe_wb_arbiter: a request-level model predicts grants and
// broadcasts, a negedge monitor compares everything the DUT presents.
module tb_exe_wb_arbiter;
    localparam int unsigned DATA    = 32;
    localparam int unsigned UNITS   = 6;
    localparam int unsigned RF_ADDR = 6;
    localparam int unsigned ROB_ID  = 5;
    localparam int SKIP = 99;

    logic clk = 1'b0;
    logic reset_;

    exe_wb_arbiter_if #(.DATA(DATA), .UNITS(UNITS), .RF_ADDR(RF_ADDR), .ROB_ID(ROB_ID)) bus ();

    exe_wb_arbiter #(.DATA(DATA), .UNITS(UNITS), .RF_ADDR(RF_ADDR), .ROB_ID(ROB_ID)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 due;
        logic [RF_ADDR-1:0] rd;
        logic [ROB_ID-1:0]  rob;
        logic [DATA-1:0]    data;
        logic               exp_n;
    } bcast_t;

    bcast_t exp_q[$];
    bcast_t mon_e;
    logic   mon_due;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int               m_ptr   = 0;
    logic [15:0]      m_cnt   = '0;
    logic [UNITS-1:0] exp_ack = '1;

    logic               pend   [UNITS];
    logic               sticky [UNITS];
    logic [RF_ADDR-1:0] f_rd   [UNITS];
    logic [ROB_ID-1:0]  f_rob  [UNITS];
    logic [DATA-1:0]    f_data [UNITS];
    logic               f_exp  [UNITS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int u, input logic [RF_ADDR-1:0] rd, input logic [ROB_ID-1:0] rob,
                           input logic [DATA-1:0] data, input logic exp_n);
        pend[u]   = 1'b1;
        f_rd[u]   = rd;
        f_rob[u]  = rob;
        f_data[u] = data;
        f_exp[u]  = exp_n;
    endtask

    function automatic bit any_pend();
        for (int u = 0; u < UNITS; u++) if (pend[u]) return 1'b1;
        return 1'b0;
    endfunction

    // One bus cycle: drive the pending set, predict the winner, advance the model.
    task automatic step(input logic stall_n, input logic flush_n, input int want);
        int g;
        int n;
        int u;
        bcast_t e;
        logic [UNITS-1:0] want_ack;
        g = -1;
        n = 0;
        for (int i = 0; i < UNITS; i++) begin
            bus.wb_req_[i] = !pend[i];
            bus.wb_rd[i*RF_ADDR +: RF_ADDR] = f_rd[i];
            bus.wb_rob_id[i*ROB_ID +: ROB_ID] = f_rob[i];
            bus.wb_data[i*DATA +: DATA] = f_data[i];
            bus.wb_exp_[i] = f_exp[i];
            if (pend[i]) n++;
        end
        bus.cdb_stall_ = stall_n;
        bus.flush_     = flush_n;
        if (stall_n && flush_n) begin
            for (int k = 0; k < UNITS; k++) begin
                u = (m_ptr + k) % UNITS;
                if (g < 0 && pend[u]) g = u;
            end
        end
        exp_ack = '1;
        if (g >= 0) begin
            exp_ack[g] = 1'b0;
            e.due   = cyc + 1;
            e.rd    = f_rd[g];
            e.rob   = f_rob[g];
            e.data  = f_data[g];
            e.exp_n = f_exp[g];
            exp_q.push_back(e);
        end
        if (want != SKIP) begin
            want_ack = '1;
            if (want >= 0) want_ack[want] = 1'b0;
            #1;
            check("grant", 64'(bus.wb_ack_), 64'(want_ack));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (n >= 2 && stall_n && flush_n && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (g >= 0) begin
            m_ptr = (g + 1) % UNITS;
            if (sticky[g]) f_data[g] = f_data[g] + 32'd1;
            else pend[g] = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < UNITS; i++) sticky[i] = 1'b0;
        for (int i = 0; i < 4 * UNITS && any_pend(); i++) step(1'b1, 1'b1, SKIP);
    endtask

    always @(negedge clk) begin
        mon_due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("cdb_valid_", 64'(bus.cdb_valid_), 64'(!mon_due));
        if (mon_due) begin
            mon_e = exp_q.pop_front();
            if (!bus.cdb_valid_) begin
                check("cdb_rd", 64'(bus.cdb_rd), 64'(mon_e.rd));
                check("cdb_rob_id", 64'(bus.cdb_rob_id), 64'(mon_e.rob));
                check("cdb_data", 64'(bus.cdb_data), 64'(mon_e.data));
                check("cdb_exp_", 64'(bus.cdb_exp_), 64'(mon_e.exp_n));
            end
        end
        check("wb_ack_", 64'(bus.wb_ack_), 64'(exp_ack));
        check("conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
    end

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL timeout: got no end of run expected finish by 3000000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset_         = 1'b0;
        bus.wb_req_    = '1;
        bus.wb_rd      = '0;
        bus.wb_rob_id  = '0;
        bus.wb_data    = '0;
        bus.wb_exp_    = '1;
        bus.cdb_stall_ = 1'b1;
        bus.flush_     = 1'b1;
        for (int u = 0; u < UNITS; u++) begin
            pend[u] = 1'b0; sticky[u] = 1'b0;
            f_rd[u] = '0; f_rob[u] = '0; f_data[u] = '0; f_exp[u] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.cdb_valid_), 64'(1));
        check("rst_rd", 64'(bus.cdb_rd), 64'(0));
        check("rst_rob", 64'(bus.cdb_rob_id), 64'(0));
        check("rst_data", 64'(bus.cdb_data), 64'(0));
        check("rst_exp", 64'(bus.cdb_exp_), 64'(1));
        check("rst_cnt", 64'(bus.conflict_cnt), 64'(0));
        check("rst_ack", 64'(bus.wb_ack_), 64'(6'h3F));
        reset_ = 1'b1;

        // Single request, then idle cycle carrying the broadcast.
        set_req(0, 6'd5, 5'd3, 32'hDEADBEEF, 1'b1);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, -1);

        // Bring the pointer to 0, then 0/2/5 requesting continuously.
        set_req(5, 6'd9, 5'd1, 32'h5555_0000, 1'b0);
        step(1'b1, 1'b1, 5);
        set_req(0, 6'd10, 5'd4, 32'h0000_1000, 1'b1);
        set_req(2, 6'd12, 5'd6, 32'h0000_2000, 1'b0);
        set_req(5, 6'd15, 5'd9, 32'h0000_5000, 1'b1);
        sticky[0] = 1'b1; sticky[2] = 1'b1; sticky[5] = 1'b1;
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 5);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 5);
        drain();

        // Stall holds unit 1 off for three cycles.
        set_req(1, 6'd33, 5'd17, 32'hCAFE_0001, 1'b1);
        step(1'b0, 1'b1, -1);
        step(1'b0, 1'b1, -1);
        step(1'b0, 1'b1, -1);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, -1);

        // Flush the cycle after a grant to unit 4; unit 3 waits it out.
        set_req(4, 6'd44, 5'd20, 32'hF00D_0004, 1'b0);
        step(1'b1, 1'b1, 4);
        set_req(3, 6'd43, 5'd21, 32'hF00D_0003, 1'b1);
        step(1'b1, 1'b0, -1);
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, -1);

        // Pointer wrap from 5 back to 0.
        set_req(4, 6'd1, 5'd2, 32'h1234_5678, 1'b1);
        step(1'b1, 1'b1, 4);
        set_req(5, 6'd50, 5'd25, 32'hAAAA_0005, 1'b1);
        set_req(0, 6'd51, 5'd26, 32'hAAAA_0000, 1'b0);
        step(1'b1, 1'b1, 5);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, -1);

        // Random traffic with random stalls and flushes.
        for (int i = 0; i < 400; i++) begin
            for (int u = 0; u < UNITS; u++) begin
                if (!pend[u] && $urandom_range(0, 9) < 4)
                    set_req(u, RF_ADDR'($urandom), ROB_ID'($urandom), $urandom, 1'($urandom));
            end
            step(($urandom_range(0, 4) != 0), ($urandom_range(0, 9) != 0), SKIP);
        end
        drain();

        // Sustained conflicts until the counter saturates.
        for (int u = 0; u < UNITS; u++) begin
            set_req(u, RF_ADDR'(u + 1), ROB_ID'(u + 7), 32'h7000_0000 + 32'(u << 20), 1'b1);
            sticky[u] = 1'b1;
        end
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) step(1'b1, 1'b1, SKIP);
        repeat (3) step(1'b1, 1'b1, SKIP);
        check("cnt_saturated", 64'(bus.conflict_cnt), 64'(16'hFFFF));
        drain();

        // Asynchronous reset while a broadcast is on the bus.
        set_req(0, 6'd60, 5'd30, 32'hBEEF_0000, 1'b1);
        set_req(2, 6'd62, 5'd31, 32'hBEEF_0002, 1'b0);
        sticky[0] = 1'b1; sticky[2] = 1'b1;
        step(1'b1, 1'b1, SKIP);
        step(1'b1, 1'b1, SKIP);
        check("pre_rst_valid", 64'(bus.cdb_valid_), 64'(0));
        #1;
        reset_ = 1'b0;
        exp_q.delete();
        m_ptr   = 0;
        m_cnt   = '0;
        exp_ack = '1;
        #1;
        check("async_rst_valid", 64'(bus.cdb_valid_), 64'(1));
        check("async_rst_ack", 64'(bus.wb_ack_), 64'(6'h3F));
        check("async_rst_cnt", 64'(bus.conflict_cnt), 64'(0));
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 0);
        drain();
        step(1'b1, 1'b1, -1);
        step(1'b1, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
